// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter in front of the shared slave-side bus.
//
// Master 0 is the CPU data port, master 1 a second requester (DMA / NPU master).
// One master is granted at a time. The arbiter forwards that master's request,
// address, write and wdata to the bus. It returns the bus ready, rdata and resp
// to the granted master only.
//
// Burst hold: a master keeps the grant for at most MaxBurst completed transfers
// while the other master is requesting. The grant never moves in the middle of
// a transfer.
//
// Optional build macro ARB_FIXED_PRIO_EN switches to fixed priority:
//   - IDLE ties go to master 0.
//   - Master 1 yields to master 0 at the next transfer boundary.
//   - Master 0 keeps the grant for as long as it requests.
//
// Ports:
//   clk_i, rst_ni              clock, synchronous active-low reset
//   mN_req_i/addr_i/write_i/wdata_i  master N request side (N = 0, 1)
//   mN_ready_o/rdata_o/resp_o        master N response side
//   s_trans_o/addr_o/write_o/wdata_o bus request side
//   s_ready_i/rdata_i/resp_i         bus response side
//   grant_o                    one-hot current grant (00 = idle)
module bus_arbiter #(
    parameter int unsigned DWidth   = 32,
    parameter int unsigned MaxBurst = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              m0_req_i,
    input  logic [DWidth-1:0] m0_addr_i,
    input  logic              m0_write_i,
    input  logic [DWidth-1:0] m0_wdata_i,
    output logic              m0_ready_o,
    output logic [DWidth-1:0] m0_rdata_o,
    output logic              m0_resp_o,
    input  logic              m1_req_i,
    input  logic [DWidth-1:0] m1_addr_i,
    input  logic              m1_write_i,
    input  logic [DWidth-1:0] m1_wdata_i,
    output logic              m1_ready_o,
    output logic [DWidth-1:0] m1_rdata_o,
    output logic              m1_resp_o,
    output logic              s_trans_o,
    output logic [DWidth-1:0] s_addr_o,
    output logic              s_write_o,
    output logic [DWidth-1:0] s_wdata_o,
    input  logic              s_ready_i,
    input  logic [DWidth-1:0] s_rdata_i,
    input  logic              s_resp_i,
    output logic [1:0]        grant_o
);

    localparam int unsigned    CntW   = $clog2(MaxBurst) + 1;
    localparam logic [CntW-1:0] CntMax = CntW'(MaxBurst - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGnt0 = 2'd1,
        StGnt1 = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            last_q, last_d;  // master that held the grant most recently
    logic [CntW-1:0] cnt_inc;

    // Saturates so a long uncontested burst still yields on the next done beat.
    assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (m0_req_i && m1_req_i) begin
`ifdef ARB_FIXED_PRIO_EN
                    state_d = StGnt0;
`else
                    state_d = last_q ? StGnt0 : StGnt1;
`endif
                end else if (m0_req_i) begin
                    state_d = StGnt0;
                end else if (m1_req_i) begin
                    state_d = StGnt1;
                end
            end
            StGnt0: begin
                if (!m0_req_i) begin
                    last_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = m1_req_i ? StGnt1 : StIdle;
                end else if (s_ready_i) begin
`ifdef ARB_FIXED_PRIO_EN
                    cnt_d = cnt_inc;
`else
                    if (cnt_q == CntMax && m1_req_i) begin
                        last_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = StGnt1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
`endif
                end
            end
            StGnt1: begin
                if (!m1_req_i) begin
                    last_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = m0_req_i ? StGnt0 : StIdle;
                end else if (s_ready_i) begin
`ifdef ARB_FIXED_PRIO_EN
                    if (m0_req_i) begin
`else
                    if (cnt_q == CntMax && m0_req_i) begin
`endif
                        last_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = StGnt0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Forwarding is combinational from the registered grant; a stalled transfer
    // freezes naturally because the state cannot move until ready or req drop.
    always_comb begin
        s_trans_o  = 1'b0;
        s_addr_o   = '0;
        s_write_o  = 1'b0;
        s_wdata_o  = '0;
        m0_ready_o = 1'b0;
        m0_rdata_o = '0;
        m0_resp_o  = 1'b0;
        m1_ready_o = 1'b0;
        m1_rdata_o = '0;
        m1_resp_o  = 1'b0;
        case (state_q)
            StGnt0: begin
                s_trans_o  = m0_req_i;
                s_addr_o   = m0_addr_i;
                s_write_o  = m0_write_i;
                s_wdata_o  = m0_wdata_i;
                m0_ready_o = s_ready_i & m0_req_i;
                m0_rdata_o = s_rdata_i;
                m0_resp_o  = s_resp_i;
            end
            StGnt1: begin
                s_trans_o  = m1_req_i;
                s_addr_o   = m1_addr_i;
                s_write_o  = m1_write_i;
                s_wdata_o  = m1_wdata_i;
                m1_ready_o = s_ready_i & m1_req_i;
                m1_rdata_o = s_rdata_i;
                m1_resp_o  = s_resp_i;
            end
            default: ;
        endcase
    end

    assign grant_o = {state_q == StGnt1, state_q == StGnt0};

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: a directed vector table, hand-written
// multi-cycle sequences and randomized stimulus, all compared against a
// transaction-level reference model.
module tb_bus_arbiter;

    localparam int DW = 32;
    localparam int MB = 4;
`ifdef ARB_FIXED_PRIO_EN
    localparam bit FixedPrio = 1'b1;
`else
    localparam bit FixedPrio = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_req, m0_write, m0_ready, m0_resp;
    logic [DW-1:0] m0_addr, m0_wdata, m0_rdata;
    logic          m1_req, m1_write, m1_ready, m1_resp;
    logic [DW-1:0] m1_addr, m1_wdata, m1_rdata;
    logic          s_trans, s_write, s_ready, s_resp;
    logic [DW-1:0] s_addr, s_wdata, s_rdata;
    logic [1:0]    grant;

    always #5 clk = ~clk;

    bus_arbiter #(.DWidth(DW), .MaxBurst(MB)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .m0_req_i   (m0_req),
        .m0_addr_i  (m0_addr),
        .m0_write_i (m0_write),
        .m0_wdata_i (m0_wdata),
        .m0_ready_o (m0_ready),
        .m0_rdata_o (m0_rdata),
        .m0_resp_o  (m0_resp),
        .m1_req_i   (m1_req),
        .m1_addr_i  (m1_addr),
        .m1_write_i (m1_write),
        .m1_wdata_i (m1_wdata),
        .m1_ready_o (m1_ready),
        .m1_rdata_o (m1_rdata),
        .m1_resp_o  (m1_resp),
        .s_trans_o  (s_trans),
        .s_addr_o   (s_addr),
        .s_write_o  (s_write),
        .s_wdata_o  (s_wdata),
        .s_ready_i  (s_ready),
        .s_rdata_i  (s_rdata),
        .s_resp_i   (s_resp),
        .grant_o    (grant)
    );

    logic [135:0] dut_out;
    assign dut_out = {grant, s_trans, s_addr, s_write, s_wdata,
                      m0_ready, m0_rdata, m0_resp, m1_ready, m1_rdata, m1_resp};

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who owns the bus (-1 none), completed beats in the
    // current tenure (unbounded), and who owned it last.
    int m_owner = -1;
    int m_beats = 0;
    int m_last  = 1;

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [135:0] model_out();
        logic [1:0]    g;
        logic          tr, w, r0, e0, r1, e1;
        logic [DW-1:0] a, wd, d0, d1;
        g = 2'b00; tr = 1'b0; w = 1'b0; r0 = 1'b0; e0 = 1'b0; r1 = 1'b0; e1 = 1'b0;
        a = '0; wd = '0; d0 = '0; d1 = '0;
        if (m_owner == 0) begin
            g = 2'b01; tr = m0_req; a = m0_addr; w = m0_write; wd = m0_wdata;
            r0 = s_ready & m0_req; d0 = s_rdata; e0 = s_resp;
        end else if (m_owner == 1) begin
            g = 2'b10; tr = m1_req; a = m1_addr; w = m1_write; wd = m1_wdata;
            r1 = s_ready & m1_req; d1 = s_rdata; e1 = s_resp;
        end
        return {g, tr, a, w, wd, r0, d0, e0, r1, d1, e1};
    endfunction

    // Applies the arbitration rules to the inputs present at the coming edge.
    task automatic model_step();
        bit own, oth, sw;
        if (!rst_n) begin
            m_owner = -1; m_beats = 0; m_last = 1;
        end else if (m_owner < 0) begin
            m_beats = 0;
            if (m0_req && m1_req) m_owner = FixedPrio ? 0 : 1 - m_last;
            else if (m0_req)      m_owner = 0;
            else if (m1_req)      m_owner = 1;
        end else begin
            own = (m_owner == 0) ? m0_req : m1_req;
            oth = (m_owner == 0) ? m1_req : m0_req;
            if (!own) begin
                m_last  = m_owner;
                m_beats = 0;
                m_owner = oth ? 1 - m_owner : -1;
            end else if (s_ready) begin
                m_beats++;
                if (FixedPrio) sw = (m_owner == 1) && oth;
                else           sw = oth && (m_beats >= MB);
                if (sw) begin
                    m_last  = m_owner;
                    m_owner = 1 - m_owner;
                    m_beats = 0;
                end
            end
        end
    endtask

    // Called at the negedge after any explicit checks for the cycle.
    task automatic finish_cycle(input string name);
        check(name, dut_out, model_out());
        model_step();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic       rst_n, m0, m1, rdy;
        logic [1:0] grant;
        logic       trans, r0, r1;
    } vec_t;

    function automatic vec_t mk(input logic rs, input logic a, input logic b, input logic r,
                                input logic [1:0] g, input logic t, input logic x0,
                                input logic x1);
        vec_t v;
        v.rst_n = rs; v.m0 = a; v.m1 = b; v.rdy = r;
        v.grant = g; v.trans = t; v.r0 = x0; v.r1 = x1;
        return v;
    endfunction

    vec_t tbl[18];
    int   pulses;

    initial begin
        // Reset phase through round-robin, release and re-grant.
        tbl[0] = mk(0, 1, 1, 1, 2'b00, 0, 0, 0);
        tbl[1] = mk(0, 1, 1, 1, 2'b00, 0, 0, 0);
        tbl[2] = mk(1, 1, 1, 0, 2'b00, 0, 0, 0);
        tbl[3] = mk(1, 1, 1, 0, 2'b01, 1, 0, 0);
        for (int i = 4; i < 8; i++) tbl[i] = mk(1, 1, 1, 1, 2'b01, 1, 1, 0);
        for (int i = 8; i < 12; i++) begin
            if (FixedPrio) tbl[i] = mk(1, 1, 1, 1, 2'b01, 1, 1, 0);
            else           tbl[i] = mk(1, 1, 1, 1, 2'b10, 1, 0, 1);
        end
        tbl[12] = mk(1, 0, 0, 0, 2'b01, 0, 0, 0);
        tbl[13] = mk(1, 0, 1, 0, 2'b00, 0, 0, 0);
        tbl[14] = mk(1, 0, 1, 0, 2'b10, 1, 0, 0);
        tbl[15] = mk(1, 0, 1, 1, 2'b10, 1, 0, 1);
        tbl[16] = mk(1, 0, 0, 0, 2'b10, 0, 0, 0);
        tbl[17] = mk(1, 0, 0, 0, 2'b00, 0, 0, 0);

        rst_n = 1'b0; m0_req = 1'b1; m1_req = 1'b1; s_ready = 1'b0; s_resp = 1'b0;
        m0_addr = 32'hA000_0010; m0_wdata = 32'h0A0A_0A0A; m0_write = 1'b1;
        m1_addr = 32'hB000_0020; m1_wdata = 32'h0B0B_0B0B; m1_write = 1'b0;
        s_rdata = 32'h5555_AAAA;
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) begin
            rst_n = tbl[i].rst_n; m0_req = tbl[i].m0; m1_req = tbl[i].m1; s_ready = tbl[i].rdy;
            @(negedge clk);
            check($sformatf("table[%0d]", i), 136'({grant, s_trans, m0_ready, m1_ready}),
                  136'({tbl[i].grant, tbl[i].trans, tbl[i].r0, tbl[i].r1}));
            finish_cycle($sformatf("table_model[%0d]", i));
        end

        // Single read by master 1 with two wait states.
        pulses = 0;
        m0_req = 1'b0; m1_req = 1'b1; m1_addr = 32'h0000_0100; m1_write = 1'b0;
        s_ready = 1'b0; s_rdata = 32'h0;
        @(negedge clk);
        check("read_idle_grant", 136'(grant), 136'(2'b00));
        finish_cycle("read_model");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("read_wait_addr", 136'({grant, s_addr, m1_ready}),
                  136'({2'b10, 32'h0000_0100, 1'b0}));
            pulses += int'(m1_ready);
            finish_cycle("read_model");
        end
        s_ready = 1'b1; s_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("read_done", 136'({m1_ready, m1_rdata, m0_ready, s_addr}),
              136'({1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0000_0100}));
        pulses += int'(m1_ready);
        finish_cycle("read_model");
        m1_req = 1'b0; s_ready = 1'b0;
        @(negedge clk);
        pulses += int'(m1_ready);
        finish_cycle("read_model");
        check("read_single_pulse", 136'(pulses), 136'(1));

        // Master 0 write stalls on its last allowed beat while master 1 waits.
        m0_req = 1'b1; m0_write = 1'b1; m0_wdata = 32'h1234_5678; m0_addr = 32'h0000_0200;
        m1_req = 1'b0; s_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            finish_cycle("freeze_lead");
        end
        s_ready = 1'b0; m1_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("freeze_hold", 136'({grant, s_write, s_wdata}),
                  136'({2'b01, 1'b1, 32'h1234_5678}));
            finish_cycle("freeze_model");
        end
        s_ready = 1'b1;
        @(negedge clk);
        check("freeze_done", 136'({grant, m0_ready}), 136'({2'b01, 1'b1}));
        finish_cycle("freeze_model");
        s_ready = 1'b0;
        @(negedge clk);
        check("freeze_switch", 136'(grant), 136'(FixedPrio ? 2'b01 : 2'b10));
        finish_cycle("freeze_model");
        m0_req = 1'b0; m1_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            finish_cycle("freeze_release");
        end

        // Randomized traffic including occasional reset.
        for (int i = 0; i < 3000; i++) begin
            rst_n    = ($urandom_range(0, 99) != 0);
            m0_req   = ($urandom_range(0, 9) < 7);
            m1_req   = ($urandom_range(0, 9) < 7);
            s_ready  = $urandom_range(0, 1) == 1;
            s_resp   = $urandom_range(0, 7) == 0;
            m0_write = $urandom_range(0, 1) == 1;
            m1_write = $urandom_range(0, 1) == 1;
            m0_addr  = $urandom; m0_wdata = $urandom;
            m1_addr  = $urandom; m1_wdata = $urandom;
            s_rdata  = $urandom;
            @(negedge clk);
            finish_cycle("random");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master arbiter in front of the shared slave-side bus, which drives the address decoder, external memory and NPU_CORE.
- Master 0 is the CPU data port. Master 1 is a second requester (DMA or NPU master).
- Grants one master at a time, forwards its request/address/write/wdata to the bus, and routes the bus ready/rdata/resp back to the granted master only.
- Round-robin arbitration, with a bounded burst hold so neither master can starve the other.

Parameters:
- DWidth, 32, data and address width.
- MaxBurst, 4, max consecutive completed transfers a master may keep while the other master is requesting (≥1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- m0_req_i  in  1  master 0 transfer request (held until m0_ready_o).
- m0_addr_i  in  DWidth  master 0 address.
- m0_write_i  in  1  master 0 write enable.
- m0_wdata_i  in  DWidth  master 0 write data.
- m0_ready_o  out  1  master 0 transfer complete.
- m0_rdata_o  out  DWidth  master 0 read data.
- m0_resp_o  out  1  master 0 error response.
- m1_req_i / m1_addr_i / m1_write_i / m1_wdata_i  in  1/DWidth/1/DWidth  master 1, same meaning as master 0.
- m1_ready_o / m1_rdata_o / m1_resp_o  out  1/DWidth/1  master 1, same meaning as master 0.
- s_trans_o  out  1  bus transfer request.
- s_addr_o  out  DWidth  bus address.
- s_write_o  out  1  bus write enable.
- s_wdata_o  out  DWidth  bus write data.
- s_ready_i  in  1  bus transfer complete.
- s_rdata_i  in  DWidth  bus read data.
- s_resp_i  in  1  bus error response.
- grant_o  out  2  one-hot current grant (00 = idle).

Behaviour:
- Clock and reset: one clock, clk_i. rst_ni is synchronous, active-low, sampled on the rising edge of clk_i.
- Reset state:
  - FSM in IDLE; burst counter = 0; last_grant = 1 (so master 0 wins the first tie).
  - All outputs 0: s_trans_o, s_addr_o, s_write_o, s_wdata_o, grant_o, mN_ready_o, mN_rdata_o, mN_resp_o.
- FSM states: IDLE, GNT0, GNT1. grant_o is decoded from the registered state.
- IDLE:
  - No requests -> stay in IDLE.
  - Exactly one request -> go to that master's GNT state.
  - Both requesting -> grant the master != last_grant.
  - Arbitration latency: 1 cycle (request seen at edge k, s_trans_o high in cycle k+1).
- GNTn (combinational forwarding):
  - s_trans_o = mn_req_i.
  - s_addr_o / s_write_o / s_wdata_o = master n's inputs.
  - mn_ready_o = s_ready_i & mn_req_i; mn_rdata_o = s_rdata_i; mn_resp_o = s_resp_i.
  - The non-granted master sees ready/rdata/resp = 0.
  - In IDLE, all s_* outputs are 0.
- Transfer done = s_trans_o & s_ready_i.
- Transitions out of GNTn (last_grant := n whenever GNTn is left):
  - mn_req_i low, other master requesting -> GNTother, counter := 0.
  - mn_req_i low, no request -> IDLE, counter := 0.
  - Done, counter == MaxBurst-1, other master requesting -> GNTother, counter := 0.
  - Done otherwise -> stay in GNTn, counter := counter+1. The counter saturates at MaxBurst-1 and is held while the other master is idle.
- No switch mid-transfer: while mn_req_i is high and s_ready_i is low, the grant and all forwarded signals are frozen, regardless of the other master's request.
- Simultaneous done on the final burst beat and a new request from the other master -> switch in the next cycle. There is no IDLE bubble.
- Reset asserted mid-transfer: returns to IDLE on that edge and all outputs go to 0. The interrupted transfer is abandoned; the master re-issues it.
- Counter width: $clog2(MaxBurst)+1.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined (fixed priority):
  - IDLE ties always go to master 0.
  - In GNT1, a master 0 request forces GNT0 at the next transfer boundary (done or m1_req_i low), regardless of the counter.
  - In GNT0, MaxBurst is ignored; master 0 keeps the grant while it requests.
- Undefined: round-robin with the MaxBurst limit exactly as in Behaviour.

Test Plan:
- Reset: hold rst_ni=0 for 2 clocks with both masters requesting -> all outputs 0 and grant_o=00 throughout; release -> grant_o=01 one cycle later.
- Single read: m1 only, addr=0x0000_0100, slave returns rdata=0xDEAD_BEEF with ready after 2 wait cycles -> m1_ready_o pulses once with m1_rdata_o=0xDEAD_BEEF; m0_ready_o stays 0; s_addr_o=0x100 held through the wait states.
- Round-robin: both request continuously, slave ready every cycle, MaxBurst=4 -> grant_o sequence is 4 done beats 01, then 4 beats 10, then 01 again, with no idle cycle between grants.
- Mid-transfer freeze: m0 granted doing a write with wdata=0x1234_5678, s_ready_i low for 5 cycles, m1 requests meanwhile -> grant_o stays 01 and s_wdata_o stays constant; switches to 10 the cycle after ready.
- Release: m0 drops request with m1 idle -> IDLE (grant_o=00) the next cycle; then m1 requests -> grant_o=10 one cycle later.
- ARB_FIXED_PRIO_EN defined, both requesting for 10 beats -> grant_o=01 for all 10 beats; m1 is granted only after m0 deasserts.
